// File: rtl/reset_request_sequencer_if.sv
// rtl/reset_request_sequencer_if.sv - request handshake and sequencer status bundle
interface reset_request_sequencer_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 req_valid;
    logic [CNT_WIDTH-1:0] req_cycles;
    logic                 req_ready;
    logic                 extend;
    logic                 assert_req;
    logic                 busy;
    logic                 done;

    modport master (
        output req_valid,
        output req_cycles,
        output extend,
        input  req_ready,
        input  assert_req,
        input  busy,
        input  done
    );

    modport slave (
        input  req_valid,
        input  req_cycles,
        input  extend,
        output req_ready,
        output assert_req,
        output busy,
        output done
    );
endinterface

// File: rtl/reset_request_sequencer.sv
// rtl/reset_request_sequencer.sv - hold/settle sequencer driving the reset generator assert input
module reset_request_sequencer #(
    parameter int CNT_WIDTH   = 8,
    parameter int MIN_HOLD    = 2,
    parameter int SETTLE      = 4,
    parameter int INIT_ASSERT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    reset_request_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MIN_HOLD_C = CNT_WIDTH'(MIN_HOLD);
    localparam logic [CNT_WIDTH-1:0] SETTLE_C   = CNT_WIDTH'(SETTLE);
    localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);
    localparam state_t               RST_STATE  = (INIT_ASSERT != 0) ? S_HOLD : S_IDLE;
    localparam logic [CNT_WIDTH-1:0] RST_CNT    = (INIT_ASSERT != 0) ? MIN_HOLD_C : '0;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // Effective hold length of the running sequence, kept so EXTEND can reload it.
    logic [CNT_WIDTH-1:0] hold_q, hold_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] eff;

    // Requests shorter than the minimum are stretched up to MIN_HOLD.
    assign eff = (bus.req_cycles < MIN_HOLD_C) ? MIN_HOLD_C : bus.req_cycles;

    // State register; reset either parks in IDLE or starts the power-on assertion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= RST_CNT;
            hold_q  <= MIN_HOLD_C;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: accept in IDLE, count down HOLD (EXTEND reloads), then SETTLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = S_HOLD;
                    cnt_d   = eff;
                    hold_d  = eff;
                end
            end
            S_HOLD: begin
                if (bus.extend) begin
                    cnt_d = hold_q;
                end else if (cnt_q == ONE_C) begin
                    if (SETTLE == 0) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_C;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            S_SETTLE: begin
                if (cnt_q == ONE_C) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.assert_req = (state_q == S_HOLD);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_reset_request_sequencer.sv
// tb/tb_reset_request_sequencer.sv - directed self-checking bench for reset_request_sequencer
module tb_reset_request_sequencer;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    reset_request_sequencer_if #(.CNT_WIDTH(8)) bus_a ();
    reset_request_sequencer_if #(.CNT_WIDTH(8)) bus_b ();

    reset_request_sequencer #(
        .CNT_WIDTH(8), .MIN_HOLD(2), .SETTLE(4), .INIT_ASSERT(1)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    reset_request_sequencer #(
        .CNT_WIDTH(8), .MIN_HOLD(2), .SETTLE(4), .INIT_ASSERT(0)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] cyc);
        bus_a.req_valid  = 1'b1;
        bus_a.req_cycles = cyc;
        tick();
        bus_a.req_valid  = 1'b0;
        bus_a.req_cycles = 8'd99;
    endtask

    // Observes dut_a from the current cycle (index 1) up to and including the DONE cycle.
    task automatic run_seq(input int ext_at, input bit ext_settle,
                           output int n_cyc, output int n_asrt, output int n_busy,
                           output int first_a, output int last_a, output bit ok);
        n_cyc = 0; n_asrt = 0; n_busy = 0; first_a = 0; last_a = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            n_cyc++;
            if (bus_a.assert_req) begin
                n_asrt++;
                if (first_a == 0) first_a = n_cyc;
                last_a = n_cyc;
            end
            if (bus_a.busy) n_busy++;
            if (bus_a.done) begin
                ok = 1'b1;
                break;
            end
            bus_a.extend = (n_cyc == ext_at) || (ext_settle && bus_a.busy && !bus_a.assert_req);
            tick();
        end
        bus_a.extend = 1'b0;
    endtask

    task automatic test_reset();
        int n_cyc, n_asrt, n_busy, first_a, last_a;
        bit ok;
        rst_a = 1'b1;
        repeat (3) tick();
        checks++; if (bus_a.assert_req !== 1'b1) begin errors++; $display("FAIL reset_assert got=%0b exp=1", bus_a.assert_req); end
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%0b exp=1", bus_a.busy); end
        checks++; if (bus_a.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", bus_a.req_ready); end
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus_a.done); end
        rst_a = 1'b0;
        run_seq(0, 1'b0, n_cyc, n_asrt, n_busy, first_a, last_a, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_timeout got=%0b exp=1", ok); end
        checks++; if (n_asrt !== 2) begin errors++; $display("FAIL init_assert_len got=%0d exp=2", n_asrt); end
        checks++; if (n_busy !== 6) begin errors++; $display("FAIL init_busy_len got=%0d exp=6", n_busy); end
        checks++; if (n_cyc !== 7) begin errors++; $display("FAIL init_done_cycle got=%0d exp=7", n_cyc); end
        checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("FAIL init_ready_at_done got=%0b exp=1", bus_a.req_ready); end
    endtask

    task automatic test_basic_request();
        int n_cyc, n_asrt, n_busy, first_a, last_a;
        bit ok;
        accept(8'd10);
        run_seq(0, 1'b0, n_cyc, n_asrt, n_busy, first_a, last_a, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL req10_timeout got=%0b exp=1", ok); end
        checks++; if (first_a !== 1) begin errors++; $display("FAIL req10_first_assert got=%0d exp=1", first_a); end
        checks++; if (last_a !== 10) begin errors++; $display("FAIL req10_last_assert got=%0d exp=10", last_a); end
        checks++; if (n_asrt !== 10) begin errors++; $display("FAIL req10_assert_len got=%0d exp=10", n_asrt); end
        checks++; if (n_cyc !== 15) begin errors++; $display("FAIL req10_done_cycle got=%0d exp=15", n_cyc); end
        tick();
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%0b exp=0", bus_a.done); end
        checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%0b exp=1", bus_a.req_ready); end
    endtask

    task automatic test_min_hold();
        int n_cyc, n_asrt, n_busy, first_a, last_a;
        bit ok;
        for (int c = 0; c < 2; c++) begin
            accept(8'(c));
            run_seq(0, 1'b0, n_cyc, n_asrt, n_busy, first_a, last_a, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clamp%0d_timeout got=%0b exp=1", c, ok); end
            checks++; if (n_asrt !== 2) begin errors++; $display("FAIL clamp%0d_assert_len got=%0d exp=2", c, n_asrt); end
            checks++; if (n_cyc !== 7) begin errors++; $display("FAIL clamp%0d_done_cycle got=%0d exp=7", c, n_cyc); end
        end
    endtask

    task automatic test_extend();
        int n_cyc, n_asrt, n_busy, first_a, last_a;
        bit ok;
        accept(8'd5);
        run_seq(4, 1'b0, n_cyc, n_asrt, n_busy, first_a, last_a, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ext4_timeout got=%0b exp=1", ok); end
        checks++; if (n_asrt !== 9) begin errors++; $display("FAIL ext4_assert_len got=%0d exp=9", n_asrt); end
        checks++; if (n_cyc !== 14) begin errors++; $display("FAIL ext4_done_cycle got=%0d exp=14", n_cyc); end
        accept(8'd5);
        run_seq(5, 1'b1, n_cyc, n_asrt, n_busy, first_a, last_a, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ext5_timeout got=%0b exp=1", ok); end
        checks++; if (n_asrt !== 10) begin errors++; $display("FAIL ext5_assert_len got=%0d exp=10", n_asrt); end
        checks++; if (n_cyc !== 15) begin errors++; $display("FAIL ext5_settle_ignored got=%0d exp=15", n_cyc); end
    endtask

    task automatic test_back_to_back();
        int n_cyc, n_asrt, n_busy, first_a, last_a;
        bit ok;
        bus_a.req_valid  = 1'b1;
        bus_a.req_cycles = 8'd3;
        tick();
        run_seq(0, 1'b0, n_cyc, n_asrt, n_busy, first_a, last_a, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout got=%0b exp=1", ok); end
        checks++; if (n_asrt !== 3) begin errors++; $display("FAIL b2b_first_len got=%0d exp=3", n_asrt); end
        checks++; if (n_cyc - last_a !== 5) begin errors++; $display("FAIL b2b_gap got=%0d exp=5", n_cyc - last_a); end
        tick();
        checks++; if (bus_a.assert_req !== 1'b1) begin errors++; $display("FAIL b2b_accept_on_done got=%0b exp=1", bus_a.assert_req); end
        run_seq(0, 1'b0, n_cyc, n_asrt, n_busy, first_a, last_a, ok);
        checks++; if (n_asrt !== 3) begin errors++; $display("FAIL b2b_second_len got=%0d exp=3", n_asrt); end
        checks++; if (n_cyc !== 8) begin errors++; $display("FAIL b2b_second_done got=%0d exp=8", n_cyc); end
        bus_a.req_valid = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int n_done;
        checks++; if (bus_b.req_ready !== 1'b1 || bus_b.assert_req !== 1'b0 || bus_b.busy !== 1'b0 || bus_b.done !== 1'b0) begin
            errors++; $display("FAIL noinit_reset got=rdy%0b/a%0b/b%0b/d%0b exp=rdy1/a0/b0/d0", bus_b.req_ready, bus_b.assert_req, bus_b.busy, bus_b.done);
        end
        rst_b = 1'b0;
        bus_b.req_valid  = 1'b1;
        bus_b.req_cycles = 8'd2;
        tick();
        bus_b.req_valid = 1'b0;
        checks++; if (bus_b.assert_req !== 1'b1) begin errors++; $display("FAIL abort_hold got=%0b exp=1", bus_b.assert_req); end
        tick();
        tick();
        checks++; if (bus_b.busy !== 1'b1 || bus_b.assert_req !== 1'b0) begin
            errors++; $display("FAIL abort_in_settle got=b%0b/a%0b exp=b1/a0", bus_b.busy, bus_b.assert_req);
        end
        rst_b = 1'b1;
        tick();
        checks++; if (bus_b.busy !== 1'b0 || bus_b.assert_req !== 1'b0 || bus_b.req_ready !== 1'b1 || bus_b.done !== 1'b0) begin
            errors++; $display("FAIL abort_state got=b%0b/a%0b/rdy%0b/d%0b exp=b0/a0/rdy1/d0", bus_b.busy, bus_b.assert_req, bus_b.req_ready, bus_b.done);
        end
        rst_b = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_b.done) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_cycles = 8'd0; bus_a.extend = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_cycles = 8'd0; bus_b.extend = 1'b0;
        test_reset();
        test_basic_request();
        test_min_hold();
        test_extend();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
